mem_split_sequencer: RTL and testbench
======================================

Name: mem_split_sequencer

Overview:
- Sequences the execute phase's single 64-bit word-addressed data-memory port for load/store micro-ops with any byte alignment.
- Accepts one byte-addressed request at a time and splits a request that crosses an 8-byte word boundary into two back-to-back word accesses, generating byte enables and shifted store data for each.
- For loads, merges the two returned words and zero-extends the result to 64 bits.
- Sits between the execute stage, which issues requests, and the data memory, which has a fixed load latency.

Parameters:
- ADDR_W, 32, byte-address width. Word address is ADDR_W-3 bits.
- LOAD_LATENCY, 1, cycles from mem_re high to valid mem_ld_data. Legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_bmd  in  2  size: 0 = 8-bit, 1 = 32-bit, 2 = 64-bit, 3 = reserved (treated as 64-bit).
- req_addr  in  ADDR_W  byte address.
- req_data  in  64  store data, right-aligned.
- mem_addr  out  ADDR_W-3  word address.
- mem_we  out  8  byte write enables.
- mem_re  out  1  read strobe.
- mem_st_data  out  64  word-aligned store data.
- mem_ld_data  in  64  read data, valid LOAD_LATENCY cycles after mem_re.
- rsp_valid  out  1  one-cycle pulse; load result valid.
- rsp_data  out  64  zero-extended load result.
- busy  out  1  request in progress (= ~req_ready).

Behaviour:
- Reset (async, rst high):
  - State goes to IDLE.
  - req_ready = 1 once reset is released.
  - mem_we, mem_re, rsp_valid, rsp_data, mem_addr and mem_st_data all = 0.
  - Any in-flight load is discarded; no response is issued.
- Accept: a request is accepted on a rising edge with req_valid & req_ready. req_ready = 1 only in IDLE. All request fields are latched at accept.
- Derived values:
  - o = addr[2:0], n = 1/4/8 bytes, w = addr[ADDR_W-1:3].
  - m = (1<<n)-1, an 8-bit mask; m = 0xFF when n = 8.
  - split = (o+n > 8).
- FSM states: IDLE, ACC0, ACC1, WAIT, RESP. All memory outputs are registered and driven only in ACC0/ACC1; they are 0 in every other state.
- ACC0 (the cycle after accept):
  - mem_addr = w.
  - Store: mem_we = (m<<o)[7:0], mem_st_data = data<<(8*o).
  - Load: mem_re = 1.
  - Next state: ACC1 if split; otherwise WAIT for a load, IDLE for a store.
- ACC1 (split only):
  - mem_addr = w+1, wrapping modulo 2^(ADDR_W-3).
  - Store: mem_we = m>>(8-o), mem_st_data = data>>(64-8*o).
  - Load: mem_re = 1.
  - Next state: WAIT for a load, IDLE for a store.
- WAIT:
  - Capture word 0 LOAD_LATENCY cycles after the ACC0 cycle: lo = ld>>(8*o).
  - If split, capture word 1 LOAD_LATENCY cycles after the ACC1 cycle: hi = ld<<(64-8*o).
  - Go to RESP in the cycle after the last capture.
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_data = (lo|hi) masked to n bytes; upper bits are 0.
  - Next state: IDLE.
- Latency, counting the accept edge as cycle 0:
  - Non-split store: writes in cycle 1; req_ready is back in cycle 2.
  - Split store: writes in cycles 1 and 2; ready in cycle 3.
  - Load: rsp_valid in cycle 1+LOAD_LATENCY+1, plus one more cycle if split; ready the next cycle.
- Stores produce no response.
- req_valid while busy is ignored. The requester must hold the request until it is accepted.
- Enables for 8-bit accesses never split. A 64-bit access with o = 0 never splits.

Test Plan:
- Aligned 64-bit store, addr 0x100, data 0x1122334455667788 -> one access in cycle 1: mem_addr 0x20, mem_we 0xFF, mem_st_data 0x1122334455667788; req_ready back in cycle 2.
- Split 64-bit store, addr 0x105, same data:
  - cycle 1: mem_addr 0x20, mem_we 0xE0, mem_st_data 0x6677880000000000;
  - cycle 2: mem_addr 0x21, mem_we 0x1F, mem_st_data 0x0000001122334455.
- Split 32-bit load, addr 0x0E, LOAD_LATENCY 1, word 0x01 returns 0xBBAA000000000000, word 0x02 returns 0x000000000000DDCC -> mem_re in cycles 1 and 2; rsp_valid pulses in cycle 4 with rsp_data 0x00000000DDCCBBAA.
- 8-bit load, addr 0x7 (o = 7), word returns 0xEE00000000000000 -> single access; rsp_data 0xEE in cycle 3; no second access.
- Wrap, ADDR_W 32, 32-bit store at 0xFFFFFFFE -> second access mem_addr 0x00000000 with mem_we 0x03.
- Reset mid-operation: assert rst during WAIT of a split load -> all outputs 0 immediately; no rsp_valid after reset is released; next request behaves normally.

Source files
------------

// File: rtl/mem_split_sequencer.sv
// Byte-addressed load/store sequencer for a 64-bit word-addressed data memory.
// Requests that cross a word boundary become two back-to-back word accesses; loads are merged and zero-extended.
module mem_split_sequencer #(
  parameter int ADDR_W       = 32,
  parameter int LOAD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_bmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [7:0]        mem_we,
  output logic              mem_re,
  output logic [63:0]       mem_st_data,
  input  logic [63:0]       mem_ld_data,
  output logic              rsp_valid,
  output logic [63:0]       rsp_data,
  output logic              busy
);
  // state | meaning
  // IDLE  | ready for a request
  // ACC0  | first (or only) word access on the memory port
  // ACC1  | second word access of a split request
  // WAIT  | load data still in flight
  // RESP  | one-cycle load response
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_t;

  localparam int WA_W = ADDR_W - 3;

  state_t            state, state_nxt;
  logic              we_q, split_q;
  logic [2:0]        o_q, tmr;
  logic [7:0]        m_q;
  logic [WA_W-1:0]   w_q;
  logic [63:0]       data_q, lo_q, hi_q;

  logic [2:0]        req_o;
  logic [3:0]        req_n;
  logic [7:0]        req_m;
  logic              req_split;
  logic [15:0]       req_m_sh;
  logic [WA_W-1:0]   addr_nxt;
  logic [7:0]        we_nxt;
  logic              re_nxt;
  logic [63:0]       st_nxt, rsp_mask;

  assign req_o = req_addr[2:0];

  always_comb begin
    req_n = 4'd8;
    req_m = 8'hFF;
    case (req_bmd)
      2'd0:    begin req_n = 4'd1; req_m = 8'h01; end
      2'd1:    begin req_n = 4'd4; req_m = 8'h0F; end
      default: begin req_n = 4'd8; req_m = 8'hFF; end
    endcase
  end

  assign req_split = ({1'b0, req_o} + req_n) > 4'd8;
  assign req_m_sh  = {8'h00, req_m} << req_o;

  always_comb begin
    state_nxt = state;
    addr_nxt  = '0;
    we_nxt    = '0;
    re_nxt    = 1'b0;
    st_nxt    = '0;
    case (state)
      IDLE: if (req_valid) begin
        state_nxt = ACC0;
        addr_nxt  = req_addr[ADDR_W-1:3];
        if (req_we) begin
          we_nxt = req_m_sh[7:0];
          st_nxt = req_data << {req_o, 3'b000};
        end else begin
          re_nxt = 1'b1;
        end
      end
      ACC0: begin
        if (split_q) begin
          state_nxt = ACC1;
          addr_nxt  = w_q + WA_W'(1);
          if (we_q) begin
            we_nxt = m_q >> (4'd8 - {1'b0, o_q});
            st_nxt = data_q >> (7'd64 - {1'b0, o_q, 3'b000});
          end else begin
            re_nxt = 1'b1;
          end
        end else begin
          state_nxt = we_q ? IDLE : WAIT;
        end
      end
      ACC1: state_nxt = we_q ? IDLE : WAIT;
      WAIT: if (split_q ? (tmr == 3'd0) : (tmr == 3'd1)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tmr counts down from accept; word 0 lands at tmr==1, word 1 at tmr==0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_addr    <= '0;
      mem_we      <= '0;
      mem_re      <= 1'b0;
      mem_st_data <= '0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      o_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      data_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      tmr         <= '0;
    end else begin
      state       <= state_nxt;
      mem_addr    <= addr_nxt;
      mem_we      <= we_nxt;
      mem_re      <= re_nxt;
      mem_st_data <= st_nxt;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        split_q <= req_split;
        o_q     <= req_o;
        m_q     <= req_m;
        w_q     <= req_addr[ADDR_W-1:3];
        data_q  <= req_data;
        lo_q    <= '0;
        hi_q    <= '0;
        tmr     <= 3'(LOAD_LATENCY + 1);
      end else if (tmr != 3'd0) begin
        tmr <= tmr - 3'd1;
      end
      if (!we_q && (state == ACC1 || state == WAIT) && tmr == 3'd1)
        lo_q <= mem_ld_data >> {o_q, 3'b000};
      if (!we_q && split_q && state == WAIT && tmr == 3'd0)
        hi_q <= mem_ld_data << (7'd64 - {1'b0, o_q, 3'b000});
    end
  end

  always_comb begin
    case (m_q)
      8'h01:   rsp_mask = 64'h0000_0000_0000_00FF;
      8'h0F:   rsp_mask = 64'h0000_0000_FFFF_FFFF;
      default: rsp_mask = '1;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_valid ? ((lo_q | hi_q) & rsp_mask) : 64'h0;
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
endmodule

// File: tb/tb_mem_split_sequencer.sv
// Directed bench for mem_split_sequencer with ADDR_W=32, LOAD_LATENCY=1 and a one-cycle memory model.
module tb_mem_split_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic        req_ready;
  logic [1:0]  req_bmd;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [28:0] mem_addr;
  logic [7:0]  mem_we;
  logic        mem_re;
  logic [63:0] mem_st_data;
  logic [63:0] mem_ld_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mem_model [logic [28:0]];

  mem_split_sequencer #(.ADDR_W(32), .LOAD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bmd(req_bmd), .req_addr(req_addr), .req_data(req_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_st_data(mem_st_data), .mem_ld_data(mem_ld_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_ld_data <= (mem_re && mem_model.exists(mem_addr)) ? mem_model[mem_addr] : 64'h0;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  // Drives a request at a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic we, input logic [1:0] bmd, input logic [31:0] addr,
                       input logic [63:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_bmd = bmd; req_addr = addr; req_data = data;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_bmd = 2'd0;
    req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b need 1", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_checks++; if ({mem_we, mem_re, rsp_valid} !== 10'h0) begin n_fail++;
      $display("FAIL reset_strobes: we=%h re=%b rsp=%b need all 0", mem_we, mem_re, rsp_valid); end
    n_checks++; if (mem_addr !== 29'h0 || mem_st_data !== 64'h0 || rsp_data !== 64'h0) begin n_fail++;
      $display("FAIL reset_data: addr=%h st=%h rsp=%h need 0", mem_addr, mem_st_data, rsp_data); end
  endtask

  task automatic test_aligned_store;
    issue(1'b1, 2'd2, 32'h100, 64'h1122334455667788);
    n_checks++; if (mem_addr !== 29'h20 || mem_we !== 8'hFF || mem_st_data !== 64'h1122334455667788) begin n_fail++;
      $display("FAIL aligned_store_c1: addr=%h we=%h st=%h need 20 ff 1122334455667788", mem_addr, mem_we, mem_st_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL aligned_store_busy: got %b need 1", busy); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || mem_we !== 8'h00) begin n_fail++;
      $display("FAIL aligned_store_c2: ready=%b we=%h need 1 00", req_ready, mem_we); end
  endtask

  task automatic test_offset_store;
    issue(1'b1, 2'd1, 32'h202, 64'h0000000012345678);
    n_checks++; if (mem_addr !== 29'h40 || mem_we !== 8'h3C || mem_st_data !== 64'h0000123456780000) begin n_fail++;
      $display("FAIL offset_store_c1: addr=%h we=%h st=%h need 40 3c 0000123456780000", mem_addr, mem_we, mem_st_data); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || mem_we !== 8'h00) begin n_fail++;
      $display("FAIL offset_store_c2: ready=%b we=%h need 1 00", req_ready, mem_we); end
  endtask

  task automatic test_split_store;
    issue(1'b1, 2'd2, 32'h105, 64'h1122334455667788);
    n_checks++; if (mem_addr !== 29'h20 || mem_we !== 8'hE0 || mem_st_data !== 64'h6677880000000000) begin n_fail++;
      $display("FAIL split_store_c1: addr=%h we=%h st=%h need 20 e0 6677880000000000", mem_addr, mem_we, mem_st_data); end
    @(negedge clk);
    n_checks++; if (mem_addr !== 29'h21 || mem_we !== 8'h1F || mem_st_data !== 64'h0000001122334455) begin n_fail++;
      $display("FAIL split_store_c2: addr=%h we=%h st=%h need 21 1f 0000001122334455", mem_addr, mem_we, mem_st_data); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL split_store_busy_c2: ready=%b need 0", req_ready); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || mem_we !== 8'h00 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL split_store_c3: ready=%b we=%h rsp=%b need 1 00 0", req_ready, mem_we, rsp_valid); end
  endtask

  task automatic test_split_load;
    mem_model[29'h01] = 64'hBBAA000000000000;
    mem_model[29'h02] = 64'h000000000000DDCC;
    issue(1'b0, 2'd1, 32'h0E, 64'h0);
    n_checks++; if (mem_re !== 1'b1 || mem_addr !== 29'h01 || mem_we !== 8'h00) begin n_fail++;
      $display("FAIL split_load_c1: re=%b addr=%h we=%h need 1 01 00", mem_re, mem_addr, mem_we); end
    @(negedge clk);
    n_checks++; if (mem_re !== 1'b1 || mem_addr !== 29'h02) begin n_fail++;
      $display("FAIL split_load_c2: re=%b addr=%h need 1 02", mem_re, mem_addr); end
    @(negedge clk);
    n_checks++; if (mem_re !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL split_load_c3: re=%b rsp=%b need 0 0", mem_re, rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h00000000DDCCBBAA) begin n_fail++;
      $display("FAIL split_load_rsp: valid=%b data=%h need 1 00000000ddccbbaa", rsp_valid, rsp_data); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL split_load_c5: rsp=%b ready=%b need 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_byte_load;
    mem_model[29'h00] = 64'hEE00000000000000;
    issue(1'b0, 2'd0, 32'h7, 64'h0);
    n_checks++; if (mem_re !== 1'b1 || mem_addr !== 29'h00) begin n_fail++;
      $display("FAIL byte_load_c1: re=%b addr=%h need 1 00", mem_re, mem_addr); end
    @(negedge clk);
    n_checks++; if (mem_re !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL byte_load_c2: re=%b rsp=%b need 0 0", mem_re, rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h00000000000000EE) begin n_fail++;
      $display("FAIL byte_load_rsp: valid=%b data=%h need 1 00000000000000ee", rsp_valid, rsp_data); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL byte_load_c4: ready=%b rsp=%b need 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_wrap;
    issue(1'b1, 2'd1, 32'hFFFFFFFE, 64'h00000000AABBCCDD);
    n_checks++; if (mem_addr !== 29'h1FFFFFFF || mem_we !== 8'hC0 || mem_st_data !== 64'hCCDD000000000000) begin n_fail++;
      $display("FAIL wrap_c1: addr=%h we=%h st=%h need 1fffffff c0 ccdd000000000000", mem_addr, mem_we, mem_st_data); end
    @(negedge clk);
    n_checks++; if (mem_addr !== 29'h0 || mem_we !== 8'h03 || mem_st_data !== 64'h000000000000AABB) begin n_fail++;
      $display("FAIL wrap_c2: addr=%h we=%h st=%h need 0 03 000000000000aabb", mem_addr, mem_we, mem_st_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int rsp_seen;
    issue(1'b0, 2'd1, 32'h0E, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if ({mem_we, mem_re, rsp_valid} !== 10'h0 || mem_addr !== 29'h0 || rsp_data !== 64'h0) begin n_fail++;
      $display("FAIL reset_mid_outputs: we=%h re=%b rsp=%b addr=%h data=%h need all 0",
               mem_we, mem_re, rsp_valid, mem_addr, rsp_data); end
    @(negedge clk);
    rst = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    n_checks++; if (rsp_seen !== 0) begin n_fail++;
      $display("FAIL reset_mid_no_rsp: got %0d responses need 0", rsp_seen); end
    mem_model[29'h20] = 64'h0123456789ABCDEF;
    issue(1'b0, 2'd2, 32'h100, 64'h0);
    n_checks++; if (mem_re !== 1'b1 || mem_addr !== 29'h20) begin n_fail++;
      $display("FAIL reset_mid_next_c1: re=%b addr=%h need 1 20", mem_re, mem_addr); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h0123456789ABCDEF) begin n_fail++;
      $display("FAIL reset_mid_next_rsp: valid=%b data=%h need 1 0123456789abcdef", rsp_valid, rsp_data); end
  endtask

  initial begin
    test_reset();
    test_aligned_store();
    test_offset_store();
    test_split_store();
    test_split_load();
    test_byte_load();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
